sine_sequencer: RTL and testbench

SINE_SEQUENCER -- requirements
Module: sine_sequencer

---
 rtl/sine_pkg.sv | 36 +++
 rtl/sine_sequencer_if.sv | 12 +
 rtl/tick_divider.sv | 35 +++
 rtl/sine_sequencer.sv | 98 +++++++++
 tb/tb_sine_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_pkg.sv
// Shared types for the sine sequencer and its lookup memory: quadrant encoding, widths, midscale.
// Also holds the phase-advance helper so the memory side and the sequencer agree on wrap rules.
package sine_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned SAMPLE_W = 10;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    PEAK   = 2'd0,
    FALL   = 2'd1,
    TROUGH = 2'd2,
    RISE   = 2'd3
  } quad_t;

  typedef struct packed {
    quad_t quad;
    addr_t addr;
  } phase_t;

  localparam sample_t MIDSCALE   = sample_t'(512);
  localparam phase_t  PHASE_ZERO = '{quad: PEAK, addr: '0};

  // A carry out of the address moves to the next quadrant; the address keeps the low bits.
  function automatic phase_t advance_phase(phase_t cur, addr_t step);
    logic [ADDR_W:0] sum;
    phase_t          nxt;
    sum      = {1'b0, cur.addr} + {1'b0, step};
    nxt.addr = sum[ADDR_W-1:0];
    nxt.quad = sum[ADDR_W] ? quad_t'(cur.quad + 2'd1) : cur.quad;
    return nxt;
  endfunction

endpackage

// File: rtl/sine_sequencer_if.sv
// Bus between the sequencer and the sine lookup memory: registered address/quadrant out,
// memory data back one cycle later. No backpressure; the memory always answers.
interface sine_sequencer_if;
  import sine_pkg::*;

  addr_t   read_address;
  quad_t   read_state;
  sample_t read_data;

  modport master (output read_address, output read_state, input read_data);
  modport slave  (input read_address, input read_state, output read_data);
endinterface

// File: rtl/tick_divider.sv
// Sample-tick divider: counts 0..DIV-1 while run is high, tick is high on the last count.
// Zero latency from count to tick; clear or a low run forces the count back to 0.
module tick_divider #(
  parameter int unsigned DIV = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned      CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || !run || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_sequencer.sv
// Steps a quadrant/address phase through an external sine memory once per tick and
// emits the looked-up sample two cycles after the tick; no backpressure on sample_out.
module sine_sequencer
  import sine_pkg::*;
#(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    restart,
  input  addr_t                   step,
  sine_sequencer_if.master        mem,
  output sample_t                 sample_out,
  output logic                    sample_valid,
  output logic                    cycle_done
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic    fsm_q, fsm_d;
  phase_t  phase_q, phase_d;
  phase_t  phase_adv;
  logic    pend_q, pend_d;
  sample_t sample_q, sample_d;
  logic    valid_q, valid_d;
  logic    done_q, done_d;
  logic    run;
  logic    tick;

  // Dropping enable in RUN already counts as idle so a pending read never lands.
  assign run       = (fsm_q == ST_RUN) && enable;
  assign phase_adv = advance_phase(phase_q, step);

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    fsm_d    = enable ? ST_RUN : ST_IDLE;
    phase_d  = phase_q;
    pend_d   = pend_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (!run) begin
      phase_d  = PHASE_ZERO;
      pend_d   = 1'b0;
      sample_d = MIDSCALE;
    end else begin
      if (pend_q) begin
        sample_d = mem.read_data;
        valid_d  = 1'b1;
        pend_d   = 1'b0;
      end
      // Restart beats a coincident tick, but a read issued earlier still completes above.
      if (restart) begin
        phase_d = PHASE_ZERO;
      end else if (tick) begin
        phase_d = phase_adv;
        pend_d  = 1'b1;
        done_d  = (phase_q.quad == RISE) && (phase_adv.quad == PEAK);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= ST_IDLE;
      phase_q  <= PHASE_ZERO;
      pend_q   <= 1'b0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign mem.read_address = phase_q.addr;
  assign mem.read_state   = phase_q.quad;
  assign sample_out       = sample_q;
  assign sample_valid     = valid_q;
  assign cycle_done       = done_q;

endmodule

// File: tb/tb_sine_sequencer.sv
// Bench for sine_sequencer with TICK_DIV = 4 and a memory returning {quadrant, address, 0}.
// Expected samples are queued as ticks are requested and popped as sample_valid arrives.
module tb_sine_sequencer;
  import sine_pkg::*;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       restart;
  logic [6:0] step;
  logic [9:0] sample_out;
  logic       sample_valid;
  logic       cycle_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  logic [6:0] m_addr;
  logic [1:0] m_quad;
  int         cd_cnt;
  int         cd_qsize;
  int         first_addr;
  int         first_valid;

  sine_sequencer_if mem_if ();

  sine_sequencer #(
    .TICK_DIV (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .restart      (restart),
    .step         (step),
    .mem          (mem_if),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .cycle_done   (cycle_done)
  );

  always #5 clk = ~clk;

  // Lookup memory stand-in: one-cycle registered read.
  always @(posedge clk) begin
    mem_if.read_data <= {mem_if.read_state, mem_if.read_address, 1'b0};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [6:0] s);
    logic [7:0] sum;
    sum = {1'b0, m_addr} + {1'b0, s};
    if (sum >= 8'd128) begin
      m_addr = 7'(sum - 8'd128);
      m_quad = m_quad + 2'd1;
    end else begin
      m_addr = sum[6:0];
    end
  endtask

  task automatic model_zero();
    m_addr = 7'd0;
    m_quad = 2'd0;
  endtask

  // Queue n expected samples at step s, then consume sample_valid pulses until drained.
  task automatic run_ticks(input int n, input logic [6:0] s);
    int   budget;
    logic pv;
    logic pd;
    step = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({m_quad, m_addr, 1'b0});
      model_step(s);
    end
    budget = n * DIV + 8;
    pv = 1'b0;
    pd = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (cycle_done) begin
        cd_cnt++;
        cd_qsize = exp_q.size();
        check_val("done_1cyc", pd, 0);
      end
      if (sample_valid) begin
        check_val("valid_1cyc", pv, 0);
        check_val("sample", sample_out, exp_q.pop_front());
      end
      pv = sample_valid;
      pd = cycle_done;
    end
    check_val("ticks_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_first_valid(input int max_c, output int at);
    at = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        at = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    restart = 1'b0;
    step    = 7'd32;
    cd_cnt  = 0;
    cd_qsize = -1;
    model_zero();

    // Reset state with enable already high.
    repeat (3) @(negedge clk);
    check_val("rst_addr", mem_if.read_address, 0);
    check_val("rst_quad", mem_if.read_state, 0);
    check_val("rst_sample", sample_out, 512);
    check_val("rst_valid", sample_valid, 0);
    check_val("rst_done", cycle_done, 0);

    // First tick at the 4th RUN cycle, sample two cycles after it.
    rst_n = 1'b1;
    first_addr  = 0;
    first_valid = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (first_addr == 0 && mem_if.read_address != 7'd0) first_addr = c;
      if (sample_valid) begin
        first_valid = c;
        break;
      end
    end
    check_val("first_addr_update", first_addr, DIV + 1);
    check_val("first_valid_cycle", first_valid, DIV + 2);
    check_val("first_sample", sample_out, 0);
    model_step(7'd32);

    // step 32 through all four quadrants; one cycle_done, after the 16th tick.
    run_ticks(15, 7'd32);
    check_val("cycle_done_count", cd_cnt, 1);
    check_val("cycle_done_at_t16", cd_qsize, 1);
    check_val("addr_after_16", mem_if.read_address, 0);
    check_val("quad_after_16", mem_if.read_state, 0);

    // Move off zero, then a plain restart between ticks.
    run_ticks(1, 7'd32);
    check_val("addr_32", mem_if.read_address, 32);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_zero();
    check_val("restart_addr", mem_if.read_address, 0);
    check_val("restart_quad", mem_if.read_state, 0);

    // step 100: 0 -> 100 -> 72/FALL -> 44/TROUGH.
    run_ticks(3, 7'd100);
    check_val("addr_step100", mem_if.read_address, 44);
    check_val("quad_step100", mem_if.read_state, 2);

    // Reach 96/TROUGH, then restart in the tick cycle.
    run_ticks(1, 7'd52);
    check_val("addr_96", mem_if.read_address, 96);
    check_val("quad_trough", mem_if.read_state, 2);
    @(negedge clk);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_val("restart_tick_addr", mem_if.read_address, 0);
    check_val("restart_tick_quad", mem_if.read_state, 0);
    model_zero();
    wait_first_valid(12, first_valid);
    check_val("restart_tick_next_valid", first_valid, DIV + 1);
    check_val("restart_tick_sample", sample_out, 0);
    model_step(7'd52);

    // Restart one cycle after a tick: the pending read still lands.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_val("pend_restart_valid", sample_valid, 1);
    check_val("pend_restart_sample", sample_out, {m_quad, m_addr, 1'b0});
    check_val("pend_restart_addr", mem_if.read_address, 0);
    model_zero();

    // Drop enable in the cycle after a tick: read discarded, back to idle.
    run_ticks(1, 7'd10);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_val("drop_valid", sample_valid, 0);
    check_val("drop_sample", sample_out, 512);
    check_val("drop_addr", mem_if.read_address, 0);
    check_val("drop_quad", mem_if.read_state, 0);
    @(negedge clk);
    check_val("drop_valid2", sample_valid, 0);
    enable = 1'b1;
    model_zero();
    wait_first_valid(12, first_valid);
    check_val("reenable_valid_cycle", first_valid, DIV + 2);
    check_val("reenable_sample", sample_out, 0);
    model_step(7'd10);
    run_ticks(2, 7'd10);
    check_val("reenable_addr", mem_if.read_address, 30);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_addr", mem_if.read_address, 0);
    check_val("arst_quad", mem_if.read_state, 0);
    check_val("arst_sample", sample_out, 512);
    check_val("arst_valid", sample_valid, 0);
    check_val("arst_done", cycle_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
